// File: rtl/lorenz_pixel_plotter_if.sv
// Bundle between the Lorenz projection/clear controller and the plotter. It carries
// the plot request handshake, the clear-screen control and status, and the write
// side of the framebuffer SRAM (its second Avalon port).
interface lorenz_pixel_plotter_if #(
  parameter int ADDR_W  = 17,
  parameter int COLOR_W = 8
);
  // plot request handshake
  logic               in_valid;
  logic               in_ready;
  logic [9:0]         in_x;
  logic [8:0]         in_y;
  logic [COLOR_W-1:0] in_color;
  // clear-screen control and status
  logic               clear_start;
  logic [COLOR_W-1:0] clear_color;
  logic               busy;
  logic               clear_done;
  logic [15:0]        drop_count;
  // SRAM port 2
  logic [ADDR_W-1:0]  sram_address;
  logic               sram_chipselect;
  logic               sram_write;
  logic [COLOR_W-1:0] sram_writedata;
  logic               sram_clken;

  // requester side: issues plots and clears, observes status and the SRAM bus
  modport master (
    output in_valid, in_x, in_y, in_color, clear_start, clear_color,
    input  in_ready, busy, clear_done, drop_count,
    input  sram_address, sram_chipselect, sram_write, sram_writedata, sram_clken
  );

  // plotter side
  modport slave (
    input  in_valid, in_x, in_y, in_color, clear_start, clear_color,
    output in_ready, busy, clear_done, drop_count,
    output sram_address, sram_chipselect, sram_write, sram_writedata, sram_clken
  );
endinterface

// File: rtl/lorenz_pixel_plotter.sv
// Write-side stage in front of the dual-port framebuffer SRAM. Turns (x, y, colour)
// plot requests into single-cycle linear-address writes, counts out-of-range
// requests, and runs a full-screen clear sweep on demand.
module lorenz_pixel_plotter #(
  parameter int H_RES   = 320,
  parameter int V_RES   = 240,
  parameter int ADDR_W  = 17,
  parameter int COLOR_W = 8
) (
  input  logic clk,
  input  logic reset,
  lorenz_pixel_plotter_if.slave bus
);

  localparam int TOTAL = H_RES * V_RES;
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(TOTAL - 1);
  localparam logic [ADDR_W-1:0] H_RES_A   = ADDR_W'(H_RES);

  typedef enum logic {
    IDLE  = 1'b0,
    CLEAR = 1'b1
  } state_t;

  state_t              r_state;
  state_t              w_state_next;

  // The SRAM-facing registers double as the single plot pipeline stage.
  logic [ADDR_W-1:0]   r_addr;
  logic [COLOR_W-1:0]  r_wdata;
  logic                r_strobe;
  logic                r_done;
  logic [15:0]         r_drop;

  logic                w_in_ready;
  logic                w_accept;
  logic                w_in_range;
  logic                w_last;
  logic [ADDR_W-1:0]   w_plot_addr;

  // A clear request in the same cycle takes priority and stalls the plot request.
  assign w_in_ready  = (r_state == IDLE) & ~bus.clear_start & ~reset;
  assign w_accept    = bus.in_valid & w_in_ready;
  assign w_in_range  = (int'(bus.in_x) < H_RES) && (int'(bus.in_y) < V_RES);
  assign w_plot_addr = ADDR_W'(bus.in_y) * H_RES_A + ADDR_W'(bus.in_x);
  // In CLEAR the strobes are high every cycle, so r_addr is the address being written now.
  assign w_last      = (r_addr == LAST_ADDR);

  // State register
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next-state logic: enter the sweep on clear_start, leave after the final address
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      IDLE:    if (bus.clear_start) w_state_next = CLEAR;
      CLEAR:   if (w_last)          w_state_next = IDLE;
      default: w_state_next = IDLE;
    endcase
  end

  // SRAM write register: plot writes in IDLE, sequential fill in CLEAR
  always_ff @(posedge clk) begin
    if (reset) begin
      r_addr   <= '0;
      r_wdata  <= '0;
      r_strobe <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (bus.clear_start) begin
            // First fill write lands next cycle; the colour stays in r_wdata for the sweep.
            r_addr   <= '0;
            r_wdata  <= bus.clear_color;
            r_strobe <= 1'b1;
          end else if (w_accept && w_in_range) begin
            r_addr   <= w_plot_addr;
            r_wdata  <= bus.in_color;
            r_strobe <= 1'b1;
          end else begin
            // Address and data hold their last value while idle.
            r_strobe <= 1'b0;
          end
        end
        CLEAR: begin
          if (w_last) begin
            // Stop on the final address rather than wrapping past the screen.
            r_strobe <= 1'b0;
          end else begin
            r_addr   <= r_addr + 1'b1;
            r_strobe <= 1'b1;
          end
        end
        default: r_strobe <= 1'b0;
      endcase
    end
  end

  // One-cycle completion pulse in the cycle after the last fill write
  always_ff @(posedge clk) begin
    if (reset) begin
      r_done <= 1'b0;
    end else begin
      r_done <= (r_state == CLEAR) && w_last;
    end
  end

  // Saturating count of accepted requests that fall off the screen
  always_ff @(posedge clk) begin
    if (reset) begin
      r_drop <= '0;
    end else if (w_accept && !w_in_range && (r_drop != 16'hFFFF)) begin
      r_drop <= r_drop + 16'd1;
    end
  end

  assign bus.in_ready        = w_in_ready;
  assign bus.busy            = (r_state == CLEAR) | r_strobe;
  assign bus.clear_done      = r_done;
  assign bus.drop_count      = r_drop;
  assign bus.sram_address    = r_addr;
  assign bus.sram_chipselect = r_strobe;
  assign bus.sram_write      = r_strobe;
  assign bus.sram_writedata  = r_wdata;
  assign bus.sram_clken      = 1'b1;

endmodule

// File: tb/tb_lorenz_pixel_plotter.sv
// Directed bench for lorenz_pixel_plotter on a reduced 20x12 screen so that clear
// sweeps stay short (240 cycles). Inputs change and outputs are sampled 1 ns after
// each rising edge.
module tb_lorenz_pixel_plotter;

  localparam int H      = 20;
  localparam int V      = 12;
  localparam int TOTAL  = H * V;
  localparam int ADDR_W = 17;
  localparam int CW     = 8;

  logic clk = 1'b0;
  logic reset;
  int   n_total = 0;
  int   n_bad   = 0;

  lorenz_pixel_plotter_if #(.ADDR_W(ADDR_W), .COLOR_W(CW)) bus ();

  lorenz_pixel_plotter #(.H_RES(H), .V_RES(V), .ADDR_W(ADDR_W), .COLOR_W(CW)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end else begin
      $display("ok   %s = %0h", tag, got);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_req(input logic v, input int x, input int y, input logic [7:0] c);
    bus.in_valid = v;
    bus.in_x     = 10'(x);
    bus.in_y     = 9'(y);
    bus.in_color = c;
  endtask

  int xs   [4] = '{0, H-1, 0,   H-1};
  int ys   [4] = '{0, 0,   V-1, V-1};
  int addr [4] = '{0, H-1, (V-1)*H, TOTAL-1};
  logic [7:0] cols [4] = '{8'h11, 8'h22, 8'h33, 8'h44};

  initial begin
    int errs;
    int strobes;
    reset           = 1'b1;
    bus.clear_start = 1'b0;
    bus.clear_color = '0;
    drive_req(1'b1, 5, 2, 8'hA3);
    tick();
    tick();
    // 1: reset state
    check_val("rst_in_ready", 32'(bus.in_ready), 0);
    reset = 1'b0;
    drive_req(1'b0, 0, 0, 8'h00);
    #1;
    check_val("rst_cs",     32'(bus.sram_chipselect), 0);
    check_val("rst_wr",     32'(bus.sram_write), 0);
    check_val("rst_addr",   32'(bus.sram_address), 0);
    check_val("rst_data",   32'(bus.sram_writedata), 0);
    check_val("rst_done",   32'(bus.clear_done), 0);
    check_val("rst_drop",   32'(bus.drop_count), 0);
    check_val("rst_busy",   32'(bus.busy), 0);
    check_val("rst_clken",  32'(bus.sram_clken), 1);
    check_val("idle_ready", 32'(bus.in_ready), 1);

    // 1: single plot (5,2) -> 2*20+5 = 45
    drive_req(1'b1, 5, 2, 8'hA3);
    tick();
    drive_req(1'b0, 0, 0, 8'h00);
    check_val("p1_cs",   32'(bus.sram_chipselect), 1);
    check_val("p1_wr",   32'(bus.sram_write), 1);
    check_val("p1_addr", 32'(bus.sram_address), 45);
    check_val("p1_data", 32'(bus.sram_writedata), 32'h A3);
    check_val("p1_busy", 32'(bus.busy), 1);
    tick();
    check_val("p1_cs_off",  32'(bus.sram_chipselect), 0);
    check_val("p1_busy_off", 32'(bus.busy), 0);
    check_val("p1_addr_hold", 32'(bus.sram_address), 45);

    // 2: four corners back to back
    for (int i = 0; i < 4; i++) begin
      drive_req(1'b1, xs[i], ys[i], cols[i]);
      #1;
      check_val($sformatf("b2b%0d_ready", i), 32'(bus.in_ready), 1);
      tick();
      check_val($sformatf("b2b%0d_cs", i),   32'(bus.sram_chipselect), 1);
      check_val($sformatf("b2b%0d_addr", i), 32'(bus.sram_address), 32'(addr[i]));
      check_val($sformatf("b2b%0d_data", i), 32'(bus.sram_writedata), 32'(cols[i]));
    end
    drive_req(1'b0, 0, 0, 8'h00);
    tick();
    check_val("b2b_cs_off", 32'(bus.sram_chipselect), 0);

    // 3: out-of-range requests are accepted but dropped
    drive_req(1'b1, H, 10, 8'h55);
    #1;
    check_val("oor1_ready", 32'(bus.in_ready), 1);
    tick();
    check_val("oor1_cs", 32'(bus.sram_chipselect), 0);
    drive_req(1'b1, 10, V, 8'h66);
    tick();
    check_val("oor2_cs", 32'(bus.sram_chipselect), 0);
    drive_req(1'b0, 0, 0, 8'h00);
    check_val("oor_drop2", 32'(bus.drop_count), 2);
    tick();
    drive_req(1'b1, H + 3, 0, 8'h77);
    strobes = 0;
    for (int j = 1; j <= 65536; j++) begin
      tick();
      if (bus.sram_chipselect) strobes++;
      if (j == 100) check_val("oor_drop102", 32'(bus.drop_count), 102);
    end
    drive_req(1'b0, 0, 0, 8'h00);
    tick();
    check_val("oor_no_writes", 32'(strobes), 0);
    check_val("oor_sat", 32'(bus.drop_count), 32'h FFFF);

    // 4: clear with colour 0x00 over the whole screen
    bus.clear_start = 1'b1;
    bus.clear_color = 8'h00;
    #1;
    check_val("clr4_ready_on_start", 32'(bus.in_ready), 0);
    tick();
    bus.clear_start = 1'b0;
    errs = 0;
    for (int k = 0; k < TOTAL; k++) begin
      if (!(bus.sram_chipselect && bus.sram_write && (int'(bus.sram_address) == k) &&
            (bus.sram_writedata == 8'h00) && !bus.in_ready && bus.busy && !bus.clear_done))
        errs++;
      tick();
    end
    check_val("clr4_sweep_errs", 32'(errs), 0);
    check_val("clr4_done",  32'(bus.clear_done), 1);
    check_val("clr4_cs_off", 32'(bus.sram_chipselect), 0);
    check_val("clr4_busy_off", 32'(bus.busy), 0);
    check_val("clr4_ready_back", 32'(bus.in_ready), 1);
    tick();
    check_val("clr4_done_once", 32'(bus.clear_done), 0);

    // 5: clear beats a simultaneous request; a second clear_start mid-sweep is ignored
    bus.clear_start = 1'b1;
    bus.clear_color = 8'h5C;
    drive_req(1'b1, 3, 4, 8'h77);
    #1;
    check_val("clr5_ready_collide", 32'(bus.in_ready), 0);
    tick();
    bus.clear_start = 1'b0;
    errs = 0;
    for (int k = 0; k < TOTAL; k++) begin
      if (!(bus.sram_chipselect && (int'(bus.sram_address) == k) &&
            (bus.sram_writedata == 8'h5C) && !bus.in_ready && !bus.clear_done))
        errs++;
      if (k == 50) begin
        bus.clear_start = 1'b1;
        bus.clear_color = 8'hEE;
      end else begin
        bus.clear_start = 1'b0;
      end
      tick();
    end
    check_val("clr5_sweep_errs", 32'(errs), 0);
    check_val("clr5_done", 32'(bus.clear_done), 1);
    check_val("clr5_ready_after", 32'(bus.in_ready), 1);
    tick();
    drive_req(1'b0, 0, 0, 8'h00);
    check_val("clr5_req_cs",   32'(bus.sram_chipselect), 1);
    check_val("clr5_req_addr", 32'(bus.sram_address), 4 * H + 3);
    check_val("clr5_req_data", 32'(bus.sram_writedata), 32'h 77);
    check_val("clr5_no_restart_done", 32'(bus.clear_done), 0);
    tick();
    check_val("clr5_idle_cs", 32'(bus.sram_chipselect), 0);

    // 6: reset in the middle of a sweep
    bus.clear_start = 1'b1;
    bus.clear_color = 8'hAA;
    tick();
    bus.clear_start = 1'b0;
    for (int k = 0; k < 100; k++) tick();
    check_val("rst6_at_addr", 32'(bus.sram_address), 100);
    reset = 1'b1;
    tick();
    check_val("rst6_cs",   32'(bus.sram_chipselect), 0);
    check_val("rst6_wr",   32'(bus.sram_write), 0);
    check_val("rst6_busy", 32'(bus.busy), 0);
    tick();
    reset = 1'b0;
    errs = 0;
    for (int k = 0; k < TOTAL + 5; k++) begin
      if (bus.clear_done || bus.sram_chipselect) errs++;
      tick();
    end
    check_val("rst6_no_done", 32'(errs), 0);
    check_val("rst6_drop_cleared", 32'(bus.drop_count), 0);
    drive_req(1'b1, 1, 1, 8'h3C);
    tick();
    drive_req(1'b0, 0, 0, 8'h00);
    check_val("rst6_plot_cs",   32'(bus.sram_chipselect), 1);
    check_val("rst6_plot_addr", 32'(bus.sram_address), H + 1);
    check_val("rst6_plot_data", 32'(bus.sram_writedata), 32'h 3C);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
